ppu_update_scheduler: RTL and testbench

//  Sits between the Avalon slave and the per-sprite display units (Mario, Goomba, Block, Ground, Tube, ...).

---
 rtl/ppu_update_scheduler.sv | 137 +++++++++++++
 tb/tb_ppu_update_scheduler.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ppu_update_scheduler.sv
// Buffers CPU sprite-register writes and releases them to the sprite units
// only during vertical blanking, so sprite state never changes mid-frame.
module ppu_update_scheduler #(
    parameter int NUM_SPRITES = 20,
    parameter int DEPTH       = 8,
    parameter int V_ACTIVE    = 480
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     chipselect,
    input  logic                     write,
    input  logic [2:0]               address,
    input  logic [31:0]              writedata,
    output logic                     waitrequest,
    input  logic [9:0]               vcount,
    output logic [NUM_SPRITES-1:0]   spr_we,
    output logic [26:0]              spr_data,
    output logic [15:0]              frame_count,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     overrun
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {
        ACTIVE,
        DRAIN,
        DONE
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [31:0]            mem [DEPTH];
    logic [AW-1:0]          wr_ptr;
    logic [AW-1:0]          rd_ptr;
    logic [LW-1:0]          budget;
    logic [LW-1:0]          budget_nxt;
    logic                   vblank;
    logic                   vblank_q;
    logic                   frame_start;
    logic                   push;
    logic                   pop;
    logic                   ovr_set;
    logic                   ovr_clr;
    logic                   fc_inc;
    logic [31:0]            head;
    logic [4:0]             head_slot;
    logic [NUM_SPRITES-1:0] we_nxt;

    assign waitrequest = (fifo_level == LW'(DEPTH));
    assign push        = chipselect & write & (address == 3'd0) & ~waitrequest;
    assign ovr_clr     = chipselect & write & (address == 3'd1);
    assign vblank      = (vcount >= 10'(V_ACTIVE));
    assign frame_start = vblank & ~vblank_q;
    assign head        = mem[rd_ptr];
    assign head_slot   = head[31:27];

    // Budget is the frame's snapshot; later pushes wait for the next vblank.
    always_comb begin
        state_nxt  = state;
        budget_nxt = budget;
        pop        = 1'b0;
        ovr_set    = 1'b0;
        fc_inc     = 1'b0;
        unique case (state)
            ACTIVE: begin
                if (frame_start) begin
                    budget_nxt = fifo_level;
                    fc_inc     = 1'b1;
                    state_nxt  = DRAIN;
                end
            end
            DRAIN: begin
                if (budget == '0) begin
                    state_nxt = DONE;
                end else if (!vblank) begin
                    ovr_set   = 1'b1;
                    state_nxt = ACTIVE;
                end else begin
                    pop        = 1'b1;
                    budget_nxt = budget - 1'b1;
                end
            end
            DONE: begin
                if (!vblank) state_nxt = ACTIVE;
            end
            default: state_nxt = ACTIVE;
        endcase
    end

    always_comb begin
        we_nxt = '0;
        for (int i = 0; i < NUM_SPRITES; i++) begin
            we_nxt[i] = pop && (32'(head_slot) == i);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= writedata;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ACTIVE;
            budget      <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_level  <= '0;
            vblank_q    <= 1'b0;
            spr_we      <= '0;
            spr_data    <= '0;
            frame_count <= '0;
            overrun     <= 1'b0;
        end else begin
            state    <= state_nxt;
            budget   <= budget_nxt;
            vblank_q <= vblank;
            spr_we   <= we_nxt;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr   <= rd_ptr + 1'b1;
                spr_data <= head[26:0];
            end
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + 1'b1;
                2'b01:   fifo_level <= fifo_level - 1'b1;
                default: fifo_level <= fifo_level;
            endcase
            if (fc_inc) frame_count <= frame_count + 16'd1;
            // A frame overrun outranks a simultaneous CPU clear.
            if (ovr_set) overrun <= 1'b1;
            else if (ovr_clr) overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ppu_update_scheduler.sv
// Directed and randomized checks of ppu_update_scheduler against a
// frame-level queue model.
module tb_ppu_update_scheduler;

    localparam int NS = 20;
    localparam int D  = 8;
    localparam int VA = 480;

    logic          clk = 1'b0;
    logic          reset;
    logic          chipselect;
    logic          write;
    logic [2:0]    address;
    logic [31:0]   writedata;
    logic          waitrequest;
    logic [9:0]    vcount;
    logic [NS-1:0] spr_we;
    logic [26:0]   spr_data;
    logic [15:0]   frame_count;
    logic [3:0]    fifo_level;
    logic          overrun;

    ppu_update_scheduler #(.NUM_SPRITES(NS), .DEPTH(D), .V_ACTIVE(VA)) dut (
        .clk(clk), .reset(reset), .chipselect(chipselect), .write(write),
        .address(address), .writedata(writedata), .waitrequest(waitrequest),
        .vcount(vcount), .spr_we(spr_we), .spr_data(spr_data),
        .frame_count(frame_count), .fifo_level(fifo_level), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0]   q[$];
    int            m_bud;
    int            m_ph;
    bit            m_vbq;
    logic [15:0]   m_fc;
    bit            m_ovr;
    logic [NS-1:0] m_we;
    logic [26:0]   m_data;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_bud  = 0;
        m_ph   = 0;
        m_vbq  = 0;
        m_fc   = '0;
        m_ovr  = 0;
        m_we   = '0;
        m_data = '0;
    endtask

    // Advance one clock; model follows the frame rules, then outputs compared.
    task automatic step();
        bit vb, fs, pu, po, st, cl;
        logic [31:0] e;
        if (reset) begin
            model_reset();
        end else begin
            vb = (vcount >= 10'(VA));
            fs = vb && !m_vbq;
            pu = chipselect && write && address == 3'd0 && q.size() < D;
            cl = chipselect && write && address == 3'd1;
            po = 0;
            st = 0;
            case (m_ph)
                0: if (fs) begin
                    m_bud = q.size();
                    m_fc  = m_fc + 16'd1;
                    m_ph  = 1;
                end
                1: if (m_bud == 0) m_ph = 2;
                   else if (!vb) begin st = 1; m_ph = 0; end
                   else begin po = 1; m_bud--; end
                default: if (!vb) m_ph = 0;
            endcase
            m_we = '0;
            if (po) begin
                e = q.pop_front();
                if (e[31:27] < NS) m_we[e[31:27]] = 1'b1;
                m_data = e[26:0];
            end
            if (pu) q.push_back(writedata);
            if (st) m_ovr = 1;
            else if (cl) m_ovr = 0;
            m_vbq = vb;
        end
        @(posedge clk);
        #1;
        chk("spr_we", 32'(spr_we), 32'(m_we));
        chk("spr_data", 32'(spr_data), 32'(m_data));
        chk("fifo_level", 32'(fifo_level), q.size());
        chk("waitrequest", 32'(waitrequest), 32'(q.size() == D));
        chk("frame_count", 32'(frame_count), 32'(m_fc));
        chk("overrun", 32'(overrun), 32'(m_ovr));
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        chipselect = 1; write = 1; address = a; writedata = d;
        step();
        chipselect = 0; write = 0; address = 0;
    endtask

    task automatic strobes(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            step();
            if (spr_we != '0) cnt++;
        end
    endtask

    initial begin
        int k;
        int cnt;
        reset = 0; chipselect = 0; write = 0; address = 0;
        writedata = 0; vcount = 10'd100;
        model_reset();
        #1 reset = 1;
        #2;
        chk("rst_async_we", 32'(spr_we), 0);
        chk("rst_async_level", 32'(fifo_level), 0);
        step();
        reset = 0;

        // Reset in the middle of a drain with budget 3.
        for (int i = 0; i < 3; i++) wr(0, {5'(i + 1), 27'(i + 16)});
        vcount = 10'd480;
        step();
        reset = 1;
        #1;
        chk("t1_async_we", 32'(spr_we), 0);
        vcount = 10'd100;
        step();
        reset = 0;
        chk("t1_we", 32'(spr_we), 0);
        chk("t1_level", 32'(fifo_level), 0);
        chk("t1_fc", 32'(frame_count), 0);
        step();
        chk("t1_idle_we", 32'(spr_we), 0);

        // Two updates released in order at vblank.
        wr(0, {5'd3, 27'h123});
        wr(0, {5'd5, 27'h456});
        strobes(3, cnt);
        chk("t2_no_early", cnt, 0);
        vcount = 10'd480;
        step();
        chk("t2_fc", 32'(frame_count), 1);
        step();
        chk("t2_we0", 32'(spr_we), 32'h8);
        chk("t2_d0", 32'(spr_data), 32'h123);
        step();
        chk("t2_we1", 32'(spr_we), 32'h20);
        chk("t2_d1", 32'(spr_data), 32'h456);
        step();
        vcount = 10'd100;
        step();

        // Full FIFO stalls the ninth write until a pop frees a slot.
        for (int i = 0; i < 8; i++) wr(0, {5'(i + 10), 27'(i * 7 + 1)});
        chk("t3_full", 32'(waitrequest), 1);
        chipselect = 1; write = 1; address = 0;
        writedata = {5'd7, 27'h5A5A5A};
        vcount = 10'd480;
        k = 0;
        while (waitrequest && k < 20) begin step(); k++; end
        chk("t3_stall_bound", 32'(k < 20), 1);
        chk("t3_stall_len", k, 2);
        step();
        chipselect = 0; write = 0;
        for (int i = 0; i < 10; i++) step();
        vcount = 10'd100;
        step();
        chk("t3_left", 32'(fifo_level), 1);
        vcount = 10'd480;
        step();
        step();
        chk("t3_we", 32'(spr_we), 32'h80);
        chk("t3_data", 32'(spr_data), 32'h5A5A5A);
        step();
        step();
        vcount = 10'd100;
        step();

        // Push on the frame_start edge is excluded from this frame's budget.
        wr(0, {5'd1, 27'h11});
        wr(0, {5'd2, 27'h22});
        vcount = 10'd480;
        wr(0, {5'd4, 27'h44});
        strobes(6, cnt);
        chk("t4_this_frame", cnt, 2);
        vcount = 10'd100;
        step();
        vcount = 10'd480;
        strobes(6, cnt);
        chk("t4_next_frame", cnt, 1);
        vcount = 10'd100;
        step();

        // Out-of-range slot is consumed without a strobe.
        wr(0, {5'd25, 27'h777});
        wr(0, {5'd9, 27'h999});
        vcount = 10'd480;
        step();
        step();
        chk("t5_bad_slot", 32'(spr_we), 0);
        step();
        chk("t5_next", 32'(spr_we), 32'h200);
        chk("t5_data", 32'(spr_data), 32'h999);
        step();
        vcount = 10'd100;
        step();

        // vblank ends early: overrun, leftovers stay queued.
        for (int i = 0; i < 4; i++) wr(0, {5'(i), 27'(i + 100)});
        vcount = 10'd480;
        step();
        step();
        chk("t6_pop", 32'(spr_we), 32'h1);
        vcount = 10'd100;
        step();
        chk("t6_ovr", 32'(overrun), 1);
        chk("t6_left", 32'(fifo_level), 3);
        wr(1, 32'h0);
        chk("t6_clr", 32'(overrun), 0);
        vcount = 10'd480;
        step();
        step();
        vcount = 10'd100;
        wr(1, 32'h0);
        chk("t6_set_wins", 32'(overrun), 1);
        chk("t6_left2", 32'(fifo_level), 2);
        wr(1, 32'h0);
        vcount = 10'd480;
        for (int i = 0; i < 5; i++) step();
        vcount = 10'd100;
        step();

        // Randomized frames of varying length against the model.
        for (int f = 0; f < 60; f++) begin
            int al = $urandom_range(4, 20);
            int vl = $urandom_range(2, 14);
            for (int c = 0; c < al + vl; c++) begin
                vcount = (c < al) ? 10'($urandom_range(0, 479))
                                  : 10'($urandom_range(480, 1023));
                chipselect = ($urandom_range(0, 2) != 0);
                write      = ($urandom_range(0, 3) != 0);
                address    = ($urandom_range(0, 5) == 0) ?
                             3'($urandom_range(0, 7)) : 3'd0;
                writedata  = $urandom;
                step();
            end
        end
        chipselect = 0;
        write = 0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
